// File: rtl/hazard3_ahbl_sram.sv
// AHB-Lite responder backed by an internal word-wide RAM, used as tightly
// coupled memory and as a CPU test target. It supports configurable wait
// states, byte-lane writes and write-to-read forwarding between back-to-back
// transfers.
// Optional feature macro: HAZARD3_AHBL_SRAM_ERR_EN. When it is defined,
// out-of-range, oversized and misaligned accesses get the two-cycle ERROR
// response. When it is undefined, the word index wraps modulo DEPTH and
// accesses are aligned down.
module hazard3_ahbl_sram #(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 1024,
    parameter int DECODE_BITS = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic              ahbls_hsel,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [3:0]               wait_count;
    logic [DECODE_BITS-1:0]   d_offset;
    logic [2:0]               d_size;
    logic                     d_write;
    logic [W_DATA-1:0]        rdata_q;
    logic [W_DATA-1:0]        mem [DEPTH];

    logic                     accept;
    logic                     addr_error;
    logic [DECODE_BITS-1:0]   a_offset;
    logic [DECODE_BITS-3:0]   rd_word;
    logic [IDX_W-1:0]         rd_idx;
    logic [IDX_W-1:0]         wr_idx;
    logic [3:0]               wr_lanes;
    logic                     commit;
    logic [W_DATA-1:0]        fwd_data;
    logic                     unused_bits;

    // Word index into the array; out-of-range words wrap around.
    function automatic logic [IDX_W-1:0] word_index(input logic [DECODE_BITS-3:0] word);
        logic [31:0] wide;
        wide = 32'(word) % 32'(DEPTH);
        return wide[IDX_W-1:0];
    endfunction

    // Little-endian byte-lane enables; oversized or misaligned sizes are aligned down.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] mask;
        if (size == 3'd0)
            mask = 4'b0001 << off;
        else if (size == 3'd1)
            mask = off[1] ? 4'b1100 : 4'b0011;
        else
            mask = 4'b1111;
        return mask;
    endfunction

    assign unused_bits = ^{ahbls_haddr[W_ADDR-1:DECODE_BITS], ahbls_htrans[0]};

    assign a_offset = ahbls_haddr[DECODE_BITS-1:0];
    assign accept   = ahbls_hsel && ahbls_htrans[1] && ahbls_hready &&
                      (state == S_IDLE || state == S_DATA || state == S_ERR2);

`ifdef HAZARD3_AHBL_SRAM_ERR_EN
    // Reject out-of-range words, oversized transfers and misaligned addresses.
    always_comb begin
        addr_error = 1'b0;
        if (32'(a_offset[DECODE_BITS-1:2]) >= 32'(DEPTH))
            addr_error = 1'b1;
        if (ahbls_hsize > 3'd2)
            addr_error = 1'b1;
        if (ahbls_hsize == 3'd1 && a_offset[0])
            addr_error = 1'b1;
        if (ahbls_hsize == 3'd2 && a_offset[1:0] != 2'b00)
            addr_error = 1'b1;
    end
`else
    assign addr_error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: new transfers are only taken while the bus is ready.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (!accept)
                    state_next = S_IDLE;
                else if (addr_error)
                    state_next = S_ERR1;
                else if (WAIT_STATES > 0)
                    state_next = S_WAIT;
                else
                    state_next = S_DATA;
            end
            S_WAIT:  state_next = (wait_count == 4'd0) ? S_DATA : S_WAIT;
            S_ERR1:  state_next = S_ERR2;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus response outputs; read data is only exposed during the DATA state.
    always_comb begin
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = 1'b0;
        ahbls_hrdata      = '0;
        case (state)
            S_WAIT: ahbls_hready_resp = 1'b0;
            S_DATA: ahbls_hrdata = rdata_q;
            S_ERR1: begin
                ahbls_hready_resp = 1'b0;
                ahbls_hresp       = 1'b1;
            end
            S_ERR2: ahbls_hresp = 1'b1;
            default: ;
        endcase
    end

    // Capture the address phase and run the wait-state countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_offset   <= '0;
            d_size     <= '0;
            d_write    <= 1'b0;
            wait_count <= '0;
        end else begin
            if (accept) begin
                d_offset   <= a_offset;
                d_size     <= ahbls_hsize;
                d_write    <= ahbls_hwrite;
                wait_count <= WAIT_INIT;
            end else if (state == S_WAIT && wait_count != 4'd0) begin
                wait_count <= wait_count - 4'd1;
            end
        end
    end

    assign commit   = (state == S_DATA) && d_write;
    assign wr_idx   = word_index(d_offset[DECODE_BITS-1:2]);
    assign wr_lanes = lane_mask(d_size, d_offset[1:0]);
    assign rd_word  = (state == S_WAIT) ? d_offset[DECODE_BITS-1:2] : a_offset[DECODE_BITS-1:2];
    assign rd_idx   = word_index(rd_word);

    // Array read with the lanes of a same-edge write merged over stale data.
    always_comb begin
        fwd_data = mem[rd_idx];
        if (commit && wr_idx == rd_idx) begin
            for (int i = 0; i < 4; i++)
                if (wr_lanes[i])
                    fwd_data[8*i +: 8] = ahbls_hwdata[8*i +: 8];
        end
    end

    // Write the enabled lanes as the write data phase completes.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++)
                if (wr_lanes[i])
                    mem[wr_idx][8*i +: 8] <= ahbls_hwdata[8*i +: 8];
        end
    end

    // Latch read data on the edge entering DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata_q <= '0;
        else if (state_next == S_DATA)
            rdata_q <= fwd_data;
    end

endmodule

// File: tb/tb_hazard3_ahbl_sram.sv
// Self-checking bench for hazard3_ahbl_sram: one instance without wait
// states and one with two wait states, each on its own single-responder bus.
// Error-response expectations follow HAZARD3_AHBL_SRAM_ERR_EN.
module tb_hazard3_ahbl_sram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel        [2];
    logic [31:0] haddr       [2];
    logic        hwrite      [2];
    logic [1:0]  htrans      [2];
    logic [2:0]  hsize       [2];
    logic [31:0] hwdata      [2];
    logic        hready_resp [2];
    logic        hresp       [2];
    logic [31:0] hrdata      [2];

    int check_count = 0;
    int pass_count  = 0;

    logic [31:0] rdata;
    int          waits;
    logic        first_resp;
    logic        last_resp;
    logic        ready_seen;

    always #5 clk = ~clk;

    hazard3_ahbl_sram #(.WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst_n(rst_n),
        .ahbls_hready(hready_resp[0]), .ahbls_hready_resp(hready_resp[0]),
        .ahbls_hresp(hresp[0]), .ahbls_hsel(hsel[0]), .ahbls_haddr(haddr[0]),
        .ahbls_hwrite(hwrite[0]), .ahbls_htrans(htrans[0]), .ahbls_hsize(hsize[0]),
        .ahbls_hwdata(hwdata[0]), .ahbls_hrdata(hrdata[0])
    );

    hazard3_ahbl_sram #(.WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .rst_n(rst_n),
        .ahbls_hready(hready_resp[1]), .ahbls_hready_resp(hready_resp[1]),
        .ahbls_hresp(hresp[1]), .ahbls_hsel(hsel[1]), .ahbls_haddr(haddr[1]),
        .ahbls_hwrite(hwrite[1]), .ahbls_htrans(htrans[1]), .ahbls_hsize(hsize[1]),
        .ahbls_hwdata(hwdata[1]), .ahbls_hrdata(hrdata[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    task automatic idleBus(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        haddr[d]  = 32'h0;
        hwrite[d] = 1'b0;
        hsize[d]  = 3'd0;
        hwdata[d] = 32'h0;
    endtask

    // One non-pipelined transfer, called just after a rising edge.
    task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 output logic [31:0] rd, output int nwait,
                                 output logic resp_first, output logic resp_last);
        logic done;
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        haddr[d]  = addr;
        hwrite[d] = wr;
        hsize[d]  = size;
        @(posedge clk); #1;
        idleBus(d);
        hwdata[d]  = wdata;
        nwait      = 0;
        rd         = 32'h0;
        resp_first = 1'b0;
        resp_last  = 1'b0;
        done       = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (c == 0)
                resp_first = hresp[d];
            if (hready_resp[d]) begin
                done      = 1'b1;
                rd        = hrdata[d];
                resp_last = hresp[d];
            end else begin
                nwait++;
            end
        end
        if (!done)
            checkOutput("transfer_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        hwdata[d] = 32'h0;
    endtask

    // Write immediately followed by a read, exercising the forwarding path.
    task automatic pipeWriteRead(input int d, input logic [31:0] waddr, input logic [2:0] wsize,
                                 input logic [31:0] wdata, input logic [31:0] raddr,
                                 output logic ready_mid, output logic [31:0] rd);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        haddr[d]  = waddr;
        hwrite[d] = 1'b1;
        hsize[d]  = wsize;
        @(posedge clk); #1;
        haddr[d]  = raddr;
        hwrite[d] = 1'b0;
        hsize[d]  = 3'd2;
        hwdata[d] = wdata;
        @(negedge clk);
        ready_mid = hready_resp[d];
        @(posedge clk); #1;
        idleBus(d);
        @(negedge clk);
        rd = hrdata[d];
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idleBus(0);
        idleBus(1);
        #2;
        checkOutput("reset_ready", 32'(hready_resp[0]), 32'd1);
        checkOutput("reset_resp", 32'(hresp[0]), 32'd0);
        checkOutput("reset_rdata", hrdata[0], 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back write then read of the same word.
        pipeWriteRead(0, 32'h10, 3'd2, 32'hDEADBEEF, 32'h10, ready_seen, rdata);
        checkOutput("fwd_ready", 32'(ready_seen), 32'd1);
        checkOutput("fwd_word", rdata, 32'hDEADBEEF);

        // Byte and halfword lane writes.
        applyStimulus(0, 1'b1, 32'h20, 3'd2, 32'h11223344, rdata, waits, first_resp, last_resp);
        applyStimulus(0, 1'b1, 32'h23, 3'd0, 32'h55000000, rdata, waits, first_resp, last_resp);
        applyStimulus(0, 1'b0, 32'h20, 3'd2, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("byte_lane3", rdata, 32'h55223344);
        checkOutput("ws0_no_wait", 32'(waits), 32'd0);
        applyStimulus(0, 1'b1, 32'h22, 3'd1, 32'hAAAA0000, rdata, waits, first_resp, last_resp);
        applyStimulus(0, 1'b0, 32'h20, 3'd2, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("half_upper", rdata, 32'hAAAA3344);

        // Partial-lane forwarding: only the written byte overrides array data.
        pipeWriteRead(0, 32'h21, 3'd0, 32'h00007700, 32'h20, ready_seen, rdata);
        checkOutput("fwd_byte", rdata, 32'hAAAA7744);

        // Wait-state instance: write and read with two wait cycles.
        applyStimulus(1, 1'b1, 32'h0, 3'd2, 32'h01020304, rdata, waits, first_resp, last_resp);
        checkOutput("ws2_write_waits", 32'(waits), 32'd2);
        applyStimulus(1, 1'b0, 32'h0, 3'd2, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("ws2_read_waits", 32'(waits), 32'd2);
        checkOutput("ws2_read_data", rdata, 32'h01020304);

        // NSEQ without hsel must be ignored.
        htrans[1] = 2'b10;
        hsel[1]   = 1'b0;
        haddr[1]  = 32'h0;
        @(posedge clk); #1;
        idleBus(1);
        @(negedge clk);
        checkOutput("unsel_ready", 32'(hready_resp[1]), 32'd1);
        checkOutput("unsel_rdata", hrdata[1], 32'h0);

        // Reset during the wait phase of a write discards the write.
        @(posedge clk); #1;
        hsel[1]   = 1'b1;
        htrans[1] = 2'b10;
        haddr[1]  = 32'h0;
        hwrite[1] = 1'b1;
        hsize[1]  = 3'd2;
        @(posedge clk); #1;
        idleBus(1);
        hwdata[1] = 32'hFFFFFFFF;
        @(negedge clk);
        checkOutput("midwait_low", 32'(hready_resp[1]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midwait_rst_ready", 32'(hready_resp[1]), 32'd1);
        checkOutput("midwait_rst_resp", 32'(hresp[1]), 32'd0);
        checkOutput("midwait_rst_rdata", hrdata[1], 32'h0);
        @(posedge clk); #1;
        hwdata[1] = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(hready_resp[1]), 32'd1);
        checkOutput("post_rst_rdata", hrdata[1], 32'h0);
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 32'h0, 3'd2, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("discarded_write", rdata, 32'h01020304);

`ifdef HAZARD3_AHBL_SRAM_ERR_EN
        applyStimulus(0, 1'b1, 32'h0, 3'd2, 32'h13579BDF, rdata, waits, first_resp, last_resp);
        applyStimulus(0, 1'b0, 32'h1000, 3'd2, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("err_range_waits", 32'(waits), 32'd1);
        checkOutput("err_range_resp1", 32'(first_resp), 32'd1);
        checkOutput("err_range_resp2", 32'(last_resp), 32'd1);
        checkOutput("err_range_rdata", rdata, 32'h0);
        applyStimulus(0, 1'b1, 32'h1, 3'd1, 32'hFFFFFFFF, rdata, waits, first_resp, last_resp);
        checkOutput("err_misalign_waits", 32'(waits), 32'd1);
        checkOutput("err_misalign_resp1", 32'(first_resp), 32'd1);
        checkOutput("err_misalign_resp2", 32'(last_resp), 32'd1);
        applyStimulus(0, 1'b0, 32'h0, 3'd3, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("err_size_resp", 32'(last_resp), 32'd1);
        applyStimulus(0, 1'b0, 32'h0, 3'd2, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("err_no_write", rdata, 32'h13579BDF);
        checkOutput("err_ok_resp", 32'(last_resp), 32'd0);
`else
        applyStimulus(0, 1'b1, 32'h1000, 3'd2, 32'hCAFEF00D, rdata, waits, first_resp, last_resp);
        checkOutput("alias_wr_resp", 32'(first_resp | last_resp), 32'd0);
        applyStimulus(0, 1'b0, 32'h0, 3'd2, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("alias_read", rdata, 32'hCAFEF00D);
        checkOutput("alias_rd_resp", 32'(first_resp | last_resp), 32'd0);
        applyStimulus(0, 1'b1, 32'h1, 3'd1, 32'h00001234, rdata, waits, first_resp, last_resp);
        checkOutput("misalign_resp", 32'(first_resp | last_resp), 32'd0);
        applyStimulus(0, 1'b0, 32'h0, 3'd2, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("misalign_half", rdata, 32'hCAFE1234);
        applyStimulus(0, 1'b1, 32'h2, 3'd3, 32'h0BADCAFE, rdata, waits, first_resp, last_resp);
        applyStimulus(0, 1'b0, 32'h0, 3'd2, 32'h0, rdata, waits, first_resp, last_resp);
        checkOutput("oversize_word", rdata, 32'h0BADCAFE);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
